ea_fixup_ctrl: RTL and testbench
================================

EA_FIXUP_CTRL -- requirements
Module: ea_fixup_ctrl

Interface
REQ-001 The block SHALL have parameter WRITE_DUMMY, default 1, meaning mode 01 always spends one dummy cycle even without a page cross.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port mode, input, 2 bits: 00 indexed read, 01 indexed write, 10 branch relative, 11 pointer increment.
REQ-006 The block SHALL have ports base_l and base_h, input, 8 bits each: the base address.
REQ-007 The block SHALL have port offset, input, 8 bits: index (unsigned) for modes 00/01, displacement (two's complement) for mode 10, ignored for mode 11.
REQ-008 The block SHALL have outputs load_pc_l, load_pc_h, l_inc, h_inc and h_dec, 1 bit each: strobes to the 16-bit address register.
REQ-009 The block SHALL have outputs pcl_in and pch_in, 8 bits each: load data to the register.
REQ-010 The block SHALL have outputs busy, done, page_cross and dummy_cycle, 1 bit each: status.

Function
REQ-011 The block SHALL implement states IDLE, LOAD, FIX, DUMMY and DONE; busy=1 in every state except IDLE.
REQ-012 In IDLE, start=1 SHALL latch mode, base and offset and move to LOAD, except mode 11, which SHALL move to DONE with l_inc=1 for that one cycle.
REQ-013 LOAD SHALL assert load_pc_l=load_pc_h=1 with pcl_in=(base_l+offset) mod 256 and pch_in=base_h.
REQ-014 Carry SHALL be bit 8 of the 9-bit sum base_l+offset.
REQ-015 For modes 00/01, cross-up SHALL equal carry; for mode 10, cross-up SHALL be carry AND offset[7]=0, and cross-down SHALL be NOT carry AND offset[7]=1.
REQ-016 From LOAD, the next state SHALL be FIX on a cross, else DUMMY if mode=01 and WRITE_DUMMY=1, else DONE.
REQ-017 FIX SHALL assert h_inc (cross-up) or h_dec (cross-down) for exactly one cycle, then go to DONE.
REQ-018 DUMMY SHALL assert dummy_cycle=1 with no strobes, then go to DONE.
REQ-019 DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-020 page_cross SHALL be registered at LOAD and held until the next accepted start.
REQ-021 At most one of load_pc_*, l_inc, h_inc and h_dec SHALL be asserted in any cycle; load_pc_l and load_pc_h count as one pair.
REQ-022 Latency from the start edge to done SHALL be: mode 11 = 1 cycle; no cross = 2 cycles; cross or write dummy = 3 cycles.
REQ-023 start while busy SHALL be ignored, with no queueing.
REQ-024 A start in DONE SHALL be ignored; a new start is accepted only in IDLE.
REQ-025 Outputs SHALL be Moore outputs decoded from the registered state and latched operands.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, clear the latched operands and drive every output to 0 (including pcl_in and pch_in), including mid-operation; any in-flight fix-up SHALL be abandoned.
REQ-027 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-028 With EA_CROSS_COUNT_EN defined, the block SHALL add output cross_cnt, 16 bits, which increments on each FIX entry, saturates at 0xFFFF and resets to 0.
REQ-029 Without EA_CROSS_COUNT_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-030 A shared package SHALL hold the mode encodings, the state enum typedef and the carry/cross helper function.
REQ-031 The block SHALL be a single module with no sub-module; the address register itself stays external.

Verification
REQ-032 Mode 00, base 0x12F0, offset 0x05: the bench SHALL see LOAD pcl_in=0xF5/pch_in=0x12, then DONE; page_cross=0; done at 2 cycles.
REQ-033 Mode 00, base 0x12F0, offset 0x20: the bench SHALL see LOAD 0x10/0x12, then FIX h_inc=1, page_cross=1, register ends at 0x1310, done at 3 cycles.
REQ-034 Mode 10, base 0x3005, offset 0xF0: the bench SHALL see LOAD 0xF5/0x30, then h_dec=1, register ends at 0x2FF5.
REQ-035 Mode 01, base 0x4000, offset 0x01, WRITE_DUMMY=1: the bench SHALL see LOAD, then dummy_cycle=1, then done; no h_inc/h_dec.
REQ-036 Mode 11 with start held high for 4 cycles: the bench SHALL see exactly one l_inc per accepted start (one every 2 cycles), and the start in DONE ignored.
REQ-037 rst_n low during FIX: the bench SHALL see all strobes 0 immediately, state IDLE, and cross_cnt=0 when EA_CROSS_COUNT_EN is defined.

Source files
------------

// File: rtl/ea_fixup_ctrl_pkg.sv
// Shared definitions for the effective-address fix-up controller:
// mode encodings, controller state type and the page-cross helper.
package ea_fixup_ctrl_pkg;

   localparam logic [1:0] MODE_IDX_RD  = 2'b00;
   localparam logic [1:0] MODE_IDX_WR  = 2'b01;
   localparam logic [1:0] MODE_BRANCH  = 2'b10;
   localparam logic [1:0] MODE_PTR_INC = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FIX   = 3'd2,
      ST_DUMMY = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Direction of the high-byte correction needed after the low-byte add.
   typedef struct packed {
      logic up;
      logic down;
   } cross_t;

   // The carry out of the 9-bit low-byte sum decides the fix-up. For an
   // unsigned index a carry always means the page moved up. For a signed
   // displacement a carry with a negative offset simply cancels the sign
   // extension, so only a positive offset with carry or a negative offset
   // without carry leaves the page.
   function automatic cross_t ea_cross(input logic [1:0] mode,
                                       input logic [7:0] base_l,
                                       input logic [7:0] offset);
      logic [8:0] sum;
      logic       carry;
      cross_t     r;
      sum    = {1'b0, base_l} + {1'b0, offset};
      carry  = sum[8];
      r.up   = 1'b0;
      r.down = 1'b0;
      case (mode)
         MODE_IDX_RD, MODE_IDX_WR: r.up = carry;
         MODE_BRANCH: begin
            r.up   = carry & ~offset[7];
            r.down = ~carry & offset[7];
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ea_fixup_ctrl.sv
// Effective-address fix-up controller. Drives load/increment/decrement
// strobes to an external 16-bit address register so that indexed,
// branch-relative and pointer-increment address forms settle correctly
// when the low-byte add crosses a page.
// Optional feature: define EA_CROSS_COUNT_EN to add the 16-bit saturating
// cross_cnt output counting fix-up cycles.
module ea_fixup_ctrl
   import ea_fixup_ctrl_pkg::*;
#(
   parameter bit WRITE_DUMMY = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [7:0]  base_l,
   input  logic [7:0]  base_h,
   input  logic [7:0]  offset,
   output logic        load_pc_l,
   output logic        load_pc_h,
   output logic        l_inc,
   output logic        h_inc,
   output logic        h_dec,
   output logic [7:0]  pcl_in,
   output logic [7:0]  pch_in,
   output logic        busy,
   output logic        done,
   output logic        page_cross,
`ifdef EA_CROSS_COUNT_EN
   output logic [15:0] cross_cnt,
`endif
   output logic        dummy_cycle
);

   state_t     state_reg, state_next;
   logic [1:0] mode_reg;
   logic [7:0] base_l_reg;
   logic [7:0] base_h_reg;
   logic [7:0] offset_reg;
   logic       page_cross_reg;
   cross_t     cr;
   logic       accept;
   logic       fix_entry;

   // Everything downstream works from the latched operands, never the live inputs.
   assign cr        = ea_cross(mode_reg, base_l_reg, offset_reg);
   assign accept    = (state_reg == ST_IDLE) && start;
   assign fix_entry = (state_reg == ST_LOAD) && (state_next == ST_FIX);

   // State register, operand latch and held page-cross flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         mode_reg       <= '0;
         base_l_reg     <= '0;
         base_h_reg     <= '0;
         offset_reg     <= '0;
         page_cross_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            mode_reg       <= mode;
            base_l_reg     <= base_l;
            base_h_reg     <= base_h;
            offset_reg     <= offset;
            page_cross_reg <= 1'b0;
         end else if (state_reg == ST_LOAD) begin
            page_cross_reg <= cr.up | cr.down;
         end
      end
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      state_next  = state_reg;
      load_pc_l   = 1'b0;
      load_pc_h   = 1'b0;
      l_inc       = 1'b0;
      h_inc       = 1'b0;
      h_dec       = 1'b0;
      pcl_in      = 8'h00;
      pch_in      = 8'h00;
      busy        = 1'b1;
      done        = 1'b0;
      dummy_cycle = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = (mode == MODE_PTR_INC) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_pc_l = 1'b1;
            load_pc_h = 1'b1;
            pcl_in    = base_l_reg + offset_reg;
            pch_in    = base_h_reg;
            if (cr.up || cr.down) begin
               state_next = ST_FIX;
            end else if ((mode_reg == MODE_IDX_WR) && WRITE_DUMMY) begin
               state_next = ST_DUMMY;
            end else begin
               state_next = ST_DONE;
            end
         end
         ST_FIX: begin
            h_inc      = cr.up;
            h_dec      = cr.down;
            state_next = ST_DONE;
         end
         ST_DUMMY: begin
            dummy_cycle = 1'b1;
            state_next  = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            l_inc      = (mode_reg == MODE_PTR_INC);
            state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   assign page_cross = page_cross_reg;

`ifdef EA_CROSS_COUNT_EN
   logic [15:0] cnt_reg;

   // Count fix-up cycles, sticking at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (fix_entry && (cnt_reg != 16'hFFFF)) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign cross_cnt = cnt_reg;
`else
   logic unused_fix_entry;
   assign unused_fix_entry = fix_entry;
`endif

endmodule

// File: tb/tb_ea_fixup_ctrl.sv
// Self-checking bench for ea_fixup_ctrl: directed address cases, random
// operations against an arithmetic model of the external address register,
// mode-11 start hold, and asynchronous reset during a fix-up.
module tb_ea_fixup_ctrl;

   localparam bit WD = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [7:0]  base_l = 8'h00;
   logic [7:0]  base_h = 8'h00;
   logic [7:0]  offset = 8'h00;
   logic        load_pc_l, load_pc_h, l_inc, h_inc, h_dec;
   logic [7:0]  pcl_in, pch_in;
   logic        busy, done, page_cross, dummy_cycle;
`ifdef EA_CROSS_COUNT_EN
   logic [15:0] cross_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   ea_fixup_ctrl #(.WRITE_DUMMY(WD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mode        (mode),
      .base_l      (base_l),
      .base_h      (base_h),
      .offset      (offset),
      .load_pc_l   (load_pc_l),
      .load_pc_h   (load_pc_h),
      .l_inc       (l_inc),
      .h_inc       (h_inc),
      .h_dec       (h_dec),
      .pcl_in      (pcl_in),
      .pch_in      (pch_in),
      .busy        (busy),
      .done        (done),
      .page_cross  (page_cross),
`ifdef EA_CROSS_COUNT_EN
      .cross_cnt   (cross_cnt),
`endif
      .dummy_cycle (dummy_cycle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_strobes"}, {load_pc_l, load_pc_h, l_inc, h_inc, h_dec}, 0);
      check({tag, "_data"}, {pch_in, pcl_in}, 0);
      check({tag, "_status"}, {busy, done, dummy_cycle}, 0);
`ifdef EA_CROSS_COUNT_EN
      check({tag, "_cross_cnt"}, cross_cnt, exp_cnt);
`endif
   endtask

   // One operation; poke keeps start high one extra edge with different
   // operands to prove busy starts are ignored and nothing is queued.
   task automatic run_op(input logic [1:0] m, input logic [15:0] base,
                         input logic [7:0] off, input bit poke);
      int lat = 0, n_load = 0, n_hinc = 0, n_hdec = 0, n_linc = 0;
      int n_dummy = 0, n_multi = 0, n_pair = 0, n_notbusy = 0;
      logic [15:0] areg;
      logic [7:0]  load_l = 8'h00, load_h = 8'h00;
      int b, bh, o, t, exp_lat;
      bit up, down;
      // reference: the address the instruction is meant to reach
      b  = int'(base);
      bh = int'(base[15:8]);
      o  = (m == 2'b10) ? int'($signed(off)) : int'(off);
      t  = (m == 2'b11) ? b : b + o;
      up   = (m != 2'b11) && (t >= (bh + 1) * 256);
      down = (m == 2'b10) && (t < bh * 256);
      exp_lat = (m == 2'b11) ? 1 : ((up || down || (m == 2'b01 && WD)) ? 3 : 2);
      areg = base;

      @(negedge clk);
      mode = m; base_l = base[7:0]; base_h = base[15:8]; offset = off; start = 1'b1;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
         @(negedge clk);
         if (poke && c == 1) begin
            mode = 2'b11; base_l = ~base[7:0]; offset = ~off;
         end else begin
            start = 1'b0;
         end
         if (!busy) n_notbusy++;
         if (load_pc_l != load_pc_h) n_pair++;
         if ((int'(load_pc_l | load_pc_h) + int'(l_inc) + int'(h_inc) + int'(h_dec)) > 1) n_multi++;
         if (load_pc_l) begin
            n_load++;
            load_l = pcl_in; load_h = pch_in;
            areg = {pch_in, pcl_in};
         end
         if (h_inc) begin n_hinc++; areg = areg + 16'h0100; end
         if (h_dec) begin n_hdec++; areg = areg - 16'h0100; end
         if (l_inc) begin n_linc++; areg[7:0] = areg[7:0] + 8'h01; end
         if (dummy_cycle) n_dummy++;
         if (done) begin
            lat = c;
            check("page_cross_at_done", page_cross, up | down);
         end
      end
      $display("[TB] op mode=%0d base=%04h off=%02h poke=%0d latency=%0d addr=%04h",
               m, base, off, poke, lat, areg);
      check("latency", lat, exp_lat);
      check("multi_strobe", n_multi, 0);
      check("load_pair", n_pair, 0);
      check("busy_during_op", n_notbusy, 0);
      check("h_inc_count", n_hinc, up);
      check("h_dec_count", n_hdec, down);
      check("dummy_count", n_dummy, (m == 2'b01 && WD && !up) ? 1 : 0);
      if (m != 2'b11) begin
         check("load_count", n_load, 1);
         check("pcl_in", load_l, 8'(base[7:0] + off));
         check("pch_in", load_h, base[15:8]);
         check("final_addr", areg, t[15:0]);
         check("l_inc_count", n_linc, 0);
      end else begin
         check("load_count", n_load, 0);
         check("l_inc_count", n_linc, 1);
      end
      if ((up || down) && exp_cnt != 65535) exp_cnt++;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", {busy, done}, 0);
      check("page_cross_held", page_cross, up | down);
`ifdef EA_CROSS_COUNT_EN
      check("cross_cnt", cross_cnt, exp_cnt);
`endif
   endtask

   initial begin
      int n_linc, n_done;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_page_cross", page_cross, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // directed cases
      run_op(2'b00, 16'h12F0, 8'h05, 1'b0);
      run_op(2'b00, 16'h12F0, 8'h20, 1'b0);
      run_op(2'b10, 16'h3005, 8'hF0, 1'b0);
      run_op(2'b01, 16'h4000, 8'h01, 1'b0);
      run_op(2'b01, 16'h40FF, 8'h01, 1'b0);
      run_op(2'b10, 16'h0010, 8'h80, 1'b0);
      run_op(2'b00, 16'hFFF0, 8'h20, 1'b1);
      run_op(2'b10, 16'h20F0, 8'h7F, 1'b1);
      run_op(2'b11, 16'h5678, 8'h00, 1'b1);

      // mode 11 with start held for four edges: one accept every two cycles
      n_linc = 0; n_done = 0;
      @(negedge clk);
      mode = 2'b11; base_l = 8'h34; base_h = 8'h12; start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 4) start = 1'b0;
         if (l_inc) n_linc++;
         if (done) n_done++;
      end
      $display("[TB] op mode=3 start held 4 cycles l_inc=%0d done=%0d", n_linc, n_done);
      check("held_l_inc", n_linc, 2);
      check("held_done", n_done, 2);

      // random operations
      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)));
      end

      // asynchronous reset in the middle of a fix-up
      @(negedge clk);
      mode = 2'b00; base_l = 8'hF0; base_h = 8'h12; offset = 8'h20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("pre_reset_load", load_pc_l, 1);
      @(negedge clk);
      check("pre_reset_fix", h_inc, 1);
      #2 rst_n = 1'b0;
      exp_cnt = 0;
      #1;
      $display("[TB] op reset asserted during fix-up");
      check_idle_outputs("mid_reset");
      check("mid_reset_page_cross", page_cross, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // first edge after release must accept
      run_op(2'b10, 16'h8000, 8'hFF, 1'b0);
      run_op(2'b00, 16'h00FF, 8'h01, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
